// File: rtl/uart_frame_pkg.sv
// Shared framing constants, state type and byte-ordering helper for the
// frame transmitter and the receive-side parser.
package uart_frame_pkg;

  localparam logic [7:0] START_BYTE = 8'hF5;
  localparam logic [7:0] STOP_BYTE  = 8'hFA;
  localparam logic [7:0] DUMP_BYTE  = 8'hF6;

  localparam int unsigned WRITE_LEN = 6;
  localparam int unsigned DUMP_LEN  = 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } frame_state_t;

  // Byte idx of a frame. Payload bytes carry at most six bits, so they can
  // never collide with the 0xF5/0xF6/0xFA markers.
  function automatic logic [7:0] frame_byte(input logic        dump,
                                            input logic [9:0]  addr,
                                            input logic [11:0] data,
                                            input logic [2:0]  idx);
    logic [7:0] b;
    b = STOP_BYTE;
    if (dump) begin
      b = DUMP_BYTE;
    end else begin
      case (idx)
        3'd0:    b = START_BYTE;
        3'd1:    b = {3'b000, addr[9:5]};
        3'd2:    b = {3'b000, addr[4:0]};
        3'd3:    b = {2'b00, data[11:6]};
        3'd4:    b = {2'b00, data[5:0]};
        default: b = STOP_BYTE;
      endcase
    end
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A new byte may be started in the last cycle of the
// previous stop bit, so consecutive bytes run with no idle gap.
module uart_tx_byte #(
  parameter int unsigned DIV = 217
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready,
  output logic       done
);

  localparam int unsigned          CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DIV - 1);

  logic             active_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       bit_q;   // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]       sh_q;
  logic             tx_q;
  logic             bit_end;

  assign bit_end = active_q && (cnt_q == CNT_LAST);
  assign done    = bit_end && (bit_q == 4'd9);
  assign ready   = !active_q || done;
  assign tx      = tx_q;

  // Bit timing, shift register and line driver.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      tx_q     <= 1'b1;
    end else if (start && ready) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
      bit_q    <= '0;
      sh_q     <= data;
      tx_q     <= 1'b0;
    end else if (done) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
    end else if (bit_end) begin
      cnt_q <= '0;
      bit_q <= bit_q + 4'd1;
      if (bit_q == 4'd8) begin
        tx_q <= 1'b1;
      end else begin
        tx_q <= sh_q[0];
        sh_q <= {1'b0, sh_q[7:1]};
      end
    end else if (active_q) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Frame transmitter: accepts write/dump requests and sequences the frame
// bytes through the byte serializer back to back.
module uart_frame_tx
  import uart_frame_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 25000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_dump,
  input  logic [9:0]  req_addr,
  input  logic [11:0] req_data,
  output logic        tx,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned DIV = CLK_FREQ / BAUD;

  frame_state_t state_q;
  logic         dump_q;
  logic [9:0]   addr_q;
  logic [11:0]  data_q;
  logic [2:0]   idx_q;
  logic         frame_done_q;

  logic         accept;
  logic         last_byte;
  logic [2:0]   next_idx;
  logic         byte_start;
  logic [7:0]   byte_data;
  logic         byte_ready;
  logic         byte_done;

  assign req_ready  = (state_q == IDLE);
  assign busy       = !req_ready;
  assign frame_done = frame_done_q;
  assign accept     = req_valid && req_ready;
  assign last_byte  = dump_q ? (idx_q == 3'(DUMP_LEN - 1))
                             : (idx_q == 3'(WRITE_LEN - 1));
  assign next_idx   = idx_q + 3'd1;

  // First byte comes straight from the request; later bytes from latched fields.
  always_comb begin
    byte_start = 1'b0;
    byte_data  = frame_byte(dump_q, addr_q, data_q, next_idx);
    if (accept) begin
      byte_start = byte_ready;
      byte_data  = frame_byte(req_dump, req_addr, req_data, 3'd0);
    end else if ((state_q == SEND) && byte_done && !last_byte) begin
      byte_start = 1'b1;
    end
  end

  // IDLE -> SEND -> IDLE sequencer; byte index advances only on stop-bit end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dump_q       <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q <= SEND;
            dump_q  <= req_dump;
            addr_q  <= req_addr;
            data_q  <= req_data;
            idx_q   <= '0;
          end
        end
        SEND: begin
          if (byte_done) begin
            if (last_byte) begin
              state_q      <= IDLE;
              frame_done_q <= 1'b1;
              idx_q        <= '0;
            end else begin
              idx_q <= next_idx;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  uart_tx_byte #(.DIV(DIV)) u_tx_byte (
    .clk   (clk),
    .rst_n (rst_n),
    .start (byte_start),
    .data  (byte_data),
    .tx    (tx),
    .ready (byte_ready),
    .done  (byte_done)
  );

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx: directed frames, back-to-back
// frames, mid-frame reset and randomized write/dump frames against a
// behavioural line model with a mid-bit decoder.
module tb_uart_frame_tx;

  localparam int unsigned CLK_FREQ = 1000000;
  localparam int unsigned BAUD     = 115200;
  localparam int          DIV      = CLK_FREQ / BAUD;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_dump  = 1'b0;
  logic [9:0]  req_addr  = '0;
  logic [11:0] req_data  = '0;
  logic        req_ready;
  logic        tx;
  logic        busy;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  uart_frame_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_dump   (req_dump),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: frame contents from plain arithmetic on the request fields.
  function automatic logic [7:0] model_byte(input logic dump, input logic [9:0] a,
                                            input logic [11:0] d, input int i);
    int vals[6];
    if (dump) return 8'hF6;
    vals = '{32'hF5, int'(a) / 32, int'(a) % 32, int'(d) / 64, int'(d) % 64, 32'hFA};
    return 8'(vals[i]);
  endfunction

  // Reference line level k cycles after the handshake (k >= 1).
  function automatic logic model_tx(input logic dump, input logic [9:0] a,
                                    input logic [11:0] d, input int k);
    int bitn;
    int pos;
    logic [7:0] b;
    bitn = (k - 1) / DIV;
    pos  = bitn % 10;
    b    = model_byte(dump, a, d, bitn / 10);
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos-1];
  endfunction

  // Called at a negedge. Presents a request and follows the full frame.
  task automatic run_frame(input string tag, input logic dump, input logic [9:0] a,
                           input logic [11:0] d, input bit hold);
    int n;
    int len;
    int wait_cyc;
    int bad_tx;
    int bad_ctl;
    int bitn;
    int pos;
    logic [7:0] got_b [6];
    n   = dump ? 1 : 6;
    len = 10 * DIV * n;
    for (int i = 0; i < 6; i++) got_b[i] = '0;
    wait_cyc = 0;
    while (req_ready !== 1'b1 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    check({tag, "_ready_before"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_dump  = dump;
    req_addr  = a;
    req_data  = d;
    @(posedge clk);
    bad_tx  = 0;
    bad_ctl = 0;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) req_valid = 1'b0;
      if (k == len / 2 && hold) begin
        req_addr = 10'($urandom);
        req_data = 12'($urandom);
        req_dump = 1'($urandom);
      end
      if (k == 1) check({tag, "_start_bit"}, 32'(tx), 32'd0);
      if (tx !== model_tx(dump, a, d, k)) bad_tx++;
      if (frame_done !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0) bad_ctl++;
      if ((k - 1) % DIV == DIV / 2) begin
        bitn = (k - 1) / DIV;
        pos  = bitn % 10;
        if (pos >= 1 && pos <= 8) got_b[bitn/10][pos-1] = tx;
      end
    end
    check({tag, "_wave_errs"}, 32'(bad_tx), 32'd0);
    check({tag, "_ctl_errs"}, 32'(bad_ctl), 32'd0);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(got_b[i]), 32'(model_byte(dump, a, d, i)));
    @(negedge clk);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd1);
    check({tag, "_ready_at_done"}, 32'(req_ready), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_tx_idle_gap"}, 32'(tx), 32'd1);
    if (!hold) begin
      @(negedge clk);
      check({tag, "_done_pulse_1cyc"}, 32'(frame_done), 32'd0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int spurious;
    logic [9:0]  ra;
    logic [11:0] rd;
    logic        rdump;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    rst_n = 1'b1;

    // Directed frames; the first is requested right after reset release
    run_frame("w3ff", 1'b0, 10'h3FF, 12'hFFF, 1'b0);
    run_frame("w155", 1'b0, 10'h155, 12'hA5C, 1'b0);
    run_frame("dump", 1'b1, 10'h3FF, 12'hFFF, 1'b0);

    // Back-to-back with req_valid held high
    run_frame("bb1", 1'b0, 10'($urandom), 12'($urandom), 1'b1);
    run_frame("bb2", 1'b0, 10'($urandom), 12'($urandom), 1'b0);

    // Reset in the middle of a write frame
    @(negedge clk);
    req_valid = 1'b1;
    req_dump  = 1'b0;
    req_addr  = 10'h2AA;
    req_data  = 12'h555;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (200) @(negedge clk);
    check("midrst_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_ready", 32'(req_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(frame_done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int k = 0; k < 10 * DIV * 6 + 4; k++) begin
      @(negedge clk);
      if (frame_done !== 1'b0 || tx !== 1'b1) spurious++;
    end
    check("midrst_no_activity", 32'(spurious), 32'd0);
    run_frame("postrst", 1'b0, 10'h0F0, 12'h0F0, 1'b0);

    // Randomized frames
    for (int f = 0; f < 64; f++) begin
      ra    = 10'($urandom);
      rd    = 12'($urandom);
      rdump = ($urandom_range(0, 7) == 0);
      run_frame($sformatf("rnd%0d", f), rdump, ra, rd, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_frame_tx.md
UART_FRAME_TX -- requirements
Module: uart_frame_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 25000000, the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, the serial bit rate.
REQ-003 SHALL have port clk  input  1  the single clock; all state is clocked on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  a frame request is presented.
REQ-006 SHALL have port req_ready  output  1  the block can accept a request.
REQ-007 SHALL have port req_dump  input  1  1 selects a dump frame, 0 selects a write frame.
REQ-008 SHALL have port req_addr  input  10  memory word address for a write frame.
REQ-009 SHALL have port req_data  input  12  memory word data for a write frame.
REQ-010 SHALL have port tx  output  1  8N1 serial line, idle high.
REQ-011 SHALL have port busy  output  1  a frame is in progress.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse when the final stop bit completes.

Function
REQ-013 SHALL define DIV = CLK_FREQ/BAUD with integer truncation (217 at the defaults); every bit lasts exactly DIV clk cycles.
REQ-014 SHALL accept a request in the cycle where req_valid and req_ready are both 1; req_dump, req_addr and req_data SHALL be latched in that cycle.
REQ-015 SHALL drive req_ready = 1 only in IDLE; requests arriving while busy SHALL be ignored and not queued.
REQ-016 For a write frame, SHALL send six bytes in this order: 0xF5, {3'b0,addr[9:5]}, {3'b0,addr[4:0]}, {2'b0,data[11:6]}, {2'b0,data[5:0]}, 0xFA.
REQ-017 For a dump frame, SHALL send the single byte 0xF6; req_addr and req_data SHALL be ignored.
REQ-018 SHALL send each byte as one start bit (0), eight data bits LSB first, then one stop bit (1).
REQ-019 SHALL insert no idle time between the bytes of a frame: the next start bit SHALL begin the cycle after the previous stop bit ends.
REQ-020 tx SHALL fall to the start bit on the cycle after the handshake cycle T.
REQ-021 frame_done SHALL pulse at T+1+10*DIV*N, where N is 6 for a write frame and 1 for a dump frame.
REQ-022 req_ready SHALL return to 1 in the same cycle as frame_done.
REQ-023 With req_valid held high, the next request SHALL be accepted on the frame_done cycle, giving one idle-high cycle between frames.
REQ-024 SHALL use the top-level state machine IDLE -> SEND -> IDLE; SEND SHALL use a byte index 0..N-1, and the byte index SHALL advance only after a stop bit completes.
REQ-025 busy SHALL equal the inverse of req_ready.
REQ-026 Payload bytes SHALL never exceed 0x3F, so they never alias 0xF5, 0xF6 or 0xFA.
REQ-027 The bit-period counter SHALL be $clog2(DIV) bits wide, SHALL count 0..DIV-1 and SHALL wrap to 0 at each bit boundary.

Reset
REQ-028 While rst_n is low: tx = 1, req_ready = 1, busy = 0, frame_done = 0, and the state SHALL be IDLE.
REQ-029 On rst_n assertion, all counters and latched fields SHALL clear immediately (asynchronously).
REQ-030 A reset mid-frame SHALL abort the frame with no frame_done pulse, and tx SHALL go high immediately.
REQ-031 After rst_n deasserts, the first request SHALL be acceptable on the first rising clk edge.

Structure
REQ-032 The constants START_BYTE 0xF5, STOP_BYTE 0xFA and DUMP_BYTE 0xF6, plus the state enum, SHALL live in shared package uart_frame_pkg, which is also used by the receive-side parser.
REQ-033 The bit-level serializer SHALL be the sub-module uart_tx_byte, with ports clk, rst_n, start, data[7:0], tx, ready and done.
REQ-034 The byte sequencing and handshake logic SHALL stay in uart_frame_tx.

Verification
REQ-035 Write request with addr 0x3FF and data 0xFFF -> decoded bytes F5 1F 1F 3F 3F FA, and frame_done at T+1+13020.
REQ-036 Write request with addr 0x155 and data 0xA5C -> decoded bytes F5 0A 15 29 1C FA, with each bit exactly 217 cycles wide.
REQ-037 Dump request (req_dump = 1, addr 0x3FF) -> only byte F6 is sent, and frame_done at T+1+2170.
REQ-038 req_valid held high with two queued writes -> two back-to-back frames with exactly one idle-high cycle between them, and inputs changed mid-frame have no effect.
REQ-039 rst_n pulsed low at cycle 5000 of a write frame -> tx is high within the same cycle, no frame_done occurs, and a new request then yields a clean full frame.
REQ-040 Loopback of tx into the codebase uart_rx at 115200 baud -> every byte decodes with o_valid asserted, over 64 random address/data pairs.
